// File: rtl/sp_apb_master.sv
// sp_apb_master: single-outstanding command/response to APB4 requester bridge with wait-state timeout
// Ports:
//   pclk, rst                      clock, synchronous active-high reset
//   cmd_valid/ready, cmd_*         request channel (addr, write, wdata, wstrb, prot)
//   rsp_valid/ready, rsp_*         response channel (rdata, err, timeout)
//   paddr..pprot, psel, penable    APB4 requester outputs
//   pready, prdata, pslverr        APB4 completer inputs
module sp_apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                    cmd_write,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 2) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic acc, tmo, fin;
  assign cmd_ready = (state == IDLE) && !rst;
  assign acc = cmd_valid && cmd_ready;
  // abort on the wait cycle that brings the count up to TIMEOUT_CYCLES
  assign tmo = (TIMEOUT_CYCLES != 0) && !pready && (cnt == TMO - 1'b1);
  assign fin = (state == ACCESS) && (pready || tmo);
  // APB strobes and response valid decode straight from the state register
  assign psel = (state == SETUP) || (state == ACCESS);
  assign penable = state == ACCESS;
  assign rsp_valid = state == RESP;
  always_comb begin
    state_n = state;
    state_n = state == IDLE   ? (acc ? SETUP : IDLE) :
              state == SETUP  ? ACCESS :
              state == ACCESS ? (fin ? RESP : ACCESS) :
                                (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= '0;
      pprot       <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) begin
        paddr  <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_write ? cmd_wdata : '0;
        pstrb  <= cmd_write ? cmd_wstrb : '0;
        pprot  <= cmd_prot;
      end
      if (state == SETUP) cnt <= '0;
      else if (state == ACCESS && !pready && cnt != '1) cnt <= cnt + 1'b1;
      if (fin) begin
        rsp_rdata   <= (pready && !pwrite) ? prdata : '0;
        rsp_err     <= pready ? pslverr : 1'b1;
        rsp_timeout <= !pready;
      end
    end
  end
endmodule

// File: tb/tb_sp_apb_master.sv
// tb_sp_apb_master: table-driven scoreboard bench for sp_apb_master with TIMEOUT_CYCLES=4
module tb_sp_apb_master;
  logic        pclk = 0, rst = 1;
  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0]  cmd_wstrb = 0;
  logic [2:0]  cmd_prot = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata, paddr, pwdata, prdata = 0;
  logic        psel, penable, pwrite, pready = 0, pslverr = 0;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  int checks = 0, errors = 0;

  sp_apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .pclk(pclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    bit          slverr;
    logic [31:0] prdata;
    int          hold;
    logic [31:0] e_rdata;
    bit          e_err;
    bit          e_to;
    int          e_lat;
  } vec_t;
  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          to;
  } exp_t;
  vec_t vecs[8];
  exp_t q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_xfer(input vec_t v);
    int lat = 0;
    bit done = 0;
    exp_t e, got;
    @(negedge pclk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    cmd_wstrb = v.strb; cmd_prot = v.prot;
    e.rdata = v.e_rdata; e.err = v.e_err; e.to = v.e_to;
    q.push_back(e);
    @(posedge pclk); #1 cmd_valid = 0;
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge pclk);
      if (rsp_valid) begin
        done = 1; lat = c;
        chk("psel_low_in_resp", {psel, penable}, 0);
        pready = 0; pslverr = 0;
      end else begin
        chk("apb_phase", {psel, penable}, {1'b1, c != 1});
        chk("apb_hold", {paddr, pwrite, pwdata, pstrb, pprot},
            {v.addr, v.wr, v.wr ? v.wdata : 32'h0, v.wr ? v.strb : 4'h0, v.prot});
        pready = (c >= 2) && (c - 2 == v.waits);
        prdata = v.prdata; pslverr = v.slverr;
      end
    end
    chk("latency", lat, v.e_lat);
    if (done && q.size() > 0) begin
      got = q.pop_front();
      chk("rsp_fields", {rsp_rdata, rsp_err, rsp_timeout}, {got.rdata, got.err, got.to});
      for (int h = 0; h < v.hold; h++) begin
        cmd_valid = 1; cmd_addr = 32'h99;
        @(negedge pclk);
        chk("hold_stable", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready, psel},
            {1'b1, got.rdata, got.err, got.to, 1'b0, 1'b0});
      end
    end
    cmd_valid = 0; rsp_ready = 1;
    @(posedge pclk); #1 rsp_ready = 0;
  endtask

  initial begin
    //          wr addr      wdata         strb  prot waits slv prdata        hold e_rdata       err to lat
    vecs[0] = '{1, 32'h10, 32'hDEADBEEF, 4'hF, 3'h0, 0,  0, 32'h11111111, 0, 32'h0,        0, 0, 3};
    vecs[1] = '{0, 32'h10, 32'h0,        4'hF, 3'h1, 3,  0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 6};
    vecs[2] = '{0, 32'h24, 32'h0,        4'h0, 3'h2, 1,  1, 32'h12345678, 0, 32'h12345678, 1, 0, 4};
    vecs[3] = '{0, 32'h30, 32'h0,        4'h0, 3'h3, 99, 0, 32'hCAFEF00D, 0, 32'h0,        1, 1, 6};
    vecs[4] = '{1, 32'h44, 32'hA5A5A5A5, 4'h3, 3'h4, 2,  0, 32'h0,        5, 32'h0,        0, 0, 5};
    vecs[5] = '{1, 32'h48, 32'h01020304, 4'h8, 3'h5, 0,  1, 32'hFFFFFFFF, 0, 32'h0,        1, 0, 3};
    vecs[6] = '{1, 32'h50, 32'h55AA55AA, 4'hC, 3'h6, 99, 0, 32'h0,        0, 32'h0,        1, 1, 6};
    vecs[7] = '{0, 32'h5C, 32'h0,        4'h0, 3'h7, 0,  0, 32'h0BADF00D, 2, 32'h0BADF00D, 0, 0, 3};
    repeat (3) @(negedge pclk);
    chk("reset_outputs", {cmd_ready, psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
                          rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);
    rst = 0; #1;
    chk("cmd_ready_after_reset", cmd_ready, 1);
    foreach (vecs[i]) do_xfer(vecs[i]);
    // reset in the middle of an ACCESS phase
    @(negedge pclk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h70; pready = 0;
    @(posedge pclk); #1 cmd_valid = 0;
    @(negedge pclk); @(negedge pclk);
    chk("mid_access", {psel, penable}, 2'b11);
    rst = 1;
    @(posedge pclk); #1;
    chk("reset_drops_apb", {psel, penable, rsp_valid, cmd_ready}, 0);
    @(negedge pclk); rst = 0; #1;
    chk("cmd_ready_after_mid_reset", cmd_ready, 1);
    repeat (3) begin
      @(negedge pclk);
      chk("no_rsp_after_reset", {rsp_valid, psel}, 0);
    end
    do_xfer(vecs[0]);
    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sp_apb_master.md
SP_APB_MASTER -- requirements
Module: sp_apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 Parameter DATA_WIDTH, default 32, APB data width (multiple of 8).
REQ-003 Parameter TIMEOUT_CYCLES, default 255, max ACCESS-phase wait cycles before abort; 0 disables timeout.
REQ-004 pclk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  request present.
REQ-007 cmd_ready  output  1  request accepted when cmd_valid&&cmd_ready.
REQ-008 cmd_addr  input  ADDR_WIDTH  byte address.
REQ-009 cmd_write  input  1  1=write, 0=read.
REQ-010 cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 cmd_wstrb  input  DATA_WIDTH/8  byte enables.
REQ-012 cmd_prot  input  3  protection attributes.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  response consumed when rsp_valid&&rsp_ready.
REQ-015 rsp_rdata  output  DATA_WIDTH  read data (0 for writes).
REQ-016 rsp_err  output  1  pslverr seen or timeout.
REQ-017 rsp_timeout  output  1  transfer aborted by timeout.
REQ-018 paddr, psel, penable, pwrite, pwdata, pstrb, pprot  outputs  ADDR_WIDTH/1/1/1/DATA_WIDTH/DATA_WIDTH/8/3  APB4 requester signals.
REQ-019 pready, prdata, pslverr  inputs  1/DATA_WIDTH/1  APB4 completer signals.

Function
REQ-020 FSM states IDLE, SETUP, ACCESS, RESP shall be implemented; one transfer in flight at most.
REQ-021 cmd_ready shall be 1 only in IDLE and while rst is low.
REQ-022 On accept in IDLE (cycle N), command fields shall be registered and the FSM shall enter SETUP: psel=1, penable=0 at N+1.
REQ-023 SETUP shall always advance to ACCESS: psel=1, penable=1 at N+2.
REQ-024 paddr, pwrite, pwdata, pstrb, pprot shall be held constant from SETUP through the final ACCESS cycle.
REQ-025 pstrb shall be driven all-zero for reads; pwdata shall be driven 0 for reads.
REQ-026 In ACCESS with pready=1: rsp_rdata=prdata for reads, 0 for writes; rsp_err=pslverr; rsp_timeout=0; next state RESP; psel=penable=0 next cycle.
REQ-027 In ACCESS with pready=0: wait counter shall increment; when counter equals TIMEOUT_CYCLES (non-zero), transfer shall abort: rsp_err=1, rsp_timeout=1, rsp_rdata=0, next state RESP, psel=penable=0.
REQ-028 Wait counter shall clear on entry to SETUP and shall saturate, never wrap.
REQ-029 RESP: rsp_valid=1 with stable rsp_* until rsp_ready=1; then IDLE next cycle.
REQ-030 Minimum transfer latency: accept at N, rsp_valid at N+3 for zero-wait completer; each pready=0 cycle adds one.
REQ-031 cmd_valid during non-IDLE states shall be ignored (not accepted, not lost—requester holds it).
REQ-032 psel shall never be 1 with penable=1 for more than one transfer; penable shall never be 1 with psel=0.
REQ-033 Outputs shall be registered; no combinational path from pready/prdata to rsp_*.

Reset
REQ-034 While rst=1 at a clock edge: state=IDLE, psel=penable=pwrite=0, paddr=pwdata=pstrb=pprot=0, rsp_valid=rsp_err=rsp_timeout=0, rsp_rdata=0, counter=0, cmd_ready=0.
REQ-035 Reset asserted mid-transfer shall drop psel/penable at the next edge and discard the in-flight transfer with no response.
REQ-036 cmd_ready shall be 1 in the first cycle after rst deasserts.

Verification
REQ-037 Write addr=0x10, wdata=0xDEADBEEF, wstrb=0xF, zero-wait completer -> psel at N+1, penable at N+2, rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
REQ-038 Read addr=0x10, completer returns prdata=0xDEADBEEF after 3 pready=0 cycles -> rsp_valid at N+6, rsp_rdata=0xDEADBEEF, pstrb=0 throughout.
REQ-039 Read with pslverr=1 on completing cycle -> rsp_err=1, rsp_timeout=0.
REQ-040 TIMEOUT_CYCLES=4, pready held 0 -> abort after 4 wait cycles, rsp_err=1, rsp_timeout=1, psel low next cycle.
REQ-041 rsp_ready held 0 for 5 cycles with cmd_valid=1 -> rsp fields stable, cmd_ready=0, no new APB transfer until response consumed.
REQ-042 rst=1 during ACCESS -> psel=penable=0 next edge, no rsp_valid, cmd_ready=1 first cycle after release.
